// File: rtl/mult_wb_arbiter_pkg.sv
// mult_wb_arbiter_pkg: shared widths, the buffered multiplier entry and the write-back source select.
package mult_wb_arbiter_pkg;
    localparam int XLEN          = 64;
    localparam int TRANS_ID_BITS = 3;
    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
    } mult_wb_entry_t;
    typedef enum logic { WB_MUL, WB_DIV } wb_sel_e;
endpackage

// File: rtl/mult_wb_fifo.sv
// mult_wb_fifo: first-word-fall-through multiplier result buffer; an incoming result bypasses an empty FIFO.
module mult_wb_fifo
    import mult_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    input  logic           i_push,
    input  mult_wb_entry_t i_data,
    input  logic           i_pop,
    output logic           o_valid,
    output mult_wb_entry_t o_data
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]    r_wptr, r_rptr;
    mult_wb_entry_t r_mem [DEPTH];
    logic           w_empty, w_full, w_push, w_wr, w_rd;
    always_comb begin
        w_empty = r_wptr == r_rptr;
        w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_push  = i_push & ~flush_i;
        w_wr    = w_push & ~(w_empty & i_pop);
        w_rd    = i_pop & ~w_empty;
        o_valid = ~w_empty | w_push;
        o_data  = w_empty ? i_data : r_mem[r_rptr[AW-1:0]];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= r_wptr + (AW+1)'(w_wr);
            r_rptr <= r_rptr + (AW+1)'(w_rd);
        end
    end
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
    // The issue credits upstream must keep this from ever happening.
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full));
endmodule

// File: rtl/mult_wb_arbiter.sv
// mult_wb_arbiter: merges buffered multiplier results and divider results onto one stallable write-back port,
// throttling multiplier issue with credits and bounding divider starvation.
module mult_wb_arbiter
    import mult_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     mul_issue_i,
    output logic                     issue_ready_o,
    input  logic                     mul_valid_i,
    input  logic [TRANS_ID_BITS-1:0] mul_trans_id_i,
    input  logic [XLEN-1:0]          mul_result_i,
    input  logic                     div_valid_i,
    input  logic [TRANS_ID_BITS-1:0] div_trans_id_i,
    input  logic [XLEN-1:0]          div_result_i,
    output logic                     div_ready_o,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_result_o,
    input  logic                     wb_ready_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0]  r_credits;
    logic [SW-1:0]  r_starve;
    logic           w_head_valid, w_kill, w_mul_pend, w_div_pend, w_fire, w_pop;
    mult_wb_entry_t w_head;
    wb_sel_e        w_sel;
    mult_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .i_push  (mul_valid_i),
        .i_data  ('{trans_id: mul_trans_id_i, result: mul_result_i}),
        .i_pop   (w_pop),
        .o_valid (w_head_valid),
        .o_data  (w_head)
    );
    // Reset also masks the combinational bypass so outputs go quiet immediately.
    always_comb begin
        w_kill        = flush_i | rst_i;
        w_mul_pend    = w_head_valid & ~w_kill;
        w_div_pend    = div_valid_i & ~w_kill;
        w_sel         = (w_div_pend && (!w_mul_pend || r_starve == SW'(STARVE_LIMIT))) ? WB_DIV : WB_MUL;
        wb_valid_o    = w_mul_pend | w_div_pend;
        w_fire        = wb_valid_o & wb_ready_i;
        w_pop         = w_fire & (w_sel == WB_MUL);
        div_ready_o   = w_fire & (w_sel == WB_DIV);
        wb_trans_id_o = !wb_valid_o ? '0 : w_sel == WB_DIV ? div_trans_id_i : w_head.trans_id;
        wb_result_o   = !wb_valid_o ? '0 : w_sel == WB_DIV ? div_result_i : w_head.result;
        issue_ready_o = (r_credits < CW'(DEPTH)) & ~flush_i;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_credits <= '0;
            r_starve  <= '0;
        end else if (flush_i) begin
            r_credits <= '0;
            r_starve  <= '0;
        end else begin
            r_credits <= r_credits + CW'(mul_issue_i) - CW'(w_pop);
            if (div_ready_o) r_starve <= '0;
            else if (w_div_pend && w_sel == WB_MUL) r_starve <= r_starve + 1'b1;
        end
    end
    a_issue_legal: assert property (@(posedge clk_i) disable iff (rst_i) !(mul_issue_i && !issue_ready_o));
endmodule
